seq_shift_unit: RTL and testbench

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

---
 rtl/shift_pkg.sv | 31 +++
 rtl/shift_step.sv | 45 ++++
 rtl/seq_shift_unit.sv | 104 ++++++++++
 tb/tb_seq_shift_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit: operation modes and FSM states.
// Raw 3-bit mode codes 5..7 all collapse to HOLD through decode_mode().
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_LSR  = 3'd0,
        MODE_ASR  = 3'd1,
        MODE_LSL  = 3'd2,
        MODE_ROR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_HOLD = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic mode_e decode_mode(input logic [2:0] raw);
        case (raw)
            3'd0:    return MODE_LSR;
            3'd1:    return MODE_ASR;
            3'd2:    return MODE_LSL;
            3'd3:    return MODE_ROR;
            3'd4:    return MODE_ROL;
            default: return MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/shift_step.sv
// One 1-bit step of the selected shift/rotate; purely combinational, zero latency.
// No flow control; ejected_bit is the bit leaving q before the step (0 for HOLD).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    output logic [WIDTH-1:0] next_q,
    output logic             ejected_bit
);

    always_comb begin
        next_q      = q;
        ejected_bit = 1'b0;
        case (mode)
            MODE_LSR: begin
                next_q      = {1'b0, q[WIDTH-1:1]};
                ejected_bit = q[0];
            end
            MODE_ASR: begin
                next_q      = {q[WIDTH-1], q[WIDTH-1:1]};
                ejected_bit = q[0];
            end
            MODE_LSL: begin
                next_q      = {q[WIDTH-2:0], 1'b0};
                ejected_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q      = {q[0], q[WIDTH-1:1]};
                ejected_bit = q[0];
            end
            MODE_ROL: begin
                next_q      = {q[WIDTH-2:0], q[WIDTH-1]};
                ejected_bit = q[WIDTH-1];
            end
            default: begin
                next_q      = q;
                ejected_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Sequential shifter: parallel load, then N single-bit steps; done pulses N+1 cycles after start.
// Commands (load/start) are ignored while busy; load wins over start in IDLE/DONE.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH-1:0] q_q;
    logic             shift_out_q;
    logic             do_load, do_start, do_step;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q           (q_q),
        .mode        (mode_q),
        .next_q      (step_q),
        .ejected_bit (step_bit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_start = 1'b0;
        do_step  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (!load_n) begin
                    do_load = 1'b1;
                end else if (start) begin
                    do_start = 1'b1;
                    state_d  = (amount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                do_step = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // HOLD steps still consume the count but leave shift_out untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q         <= '0;
            shift_out_q <= 1'b0;
            cnt_q       <= '0;
            mode_q      <= MODE_HOLD;
        end else begin
            if (do_load) begin
                q_q <= load_val;
            end else if (do_step) begin
                q_q   <= step_q;
                cnt_q <= cnt_q - CNT_ONE;
                if (mode_q != MODE_HOLD) begin
                    shift_out_q <= step_bit;
                end
            end
            if (do_start) begin
                mode_q <= decode_mode(mode);
                cnt_q  <= amount;
            end
        end
    end

    assign q         = q_q;
    assign shift_out = shift_out_q;
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit at WIDTH=8 with hand-computed expectations.
module tb_seq_shift_unit;
    import shift_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [7:0] load_val;
    logic       load_n;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] q;
    logic       shift_out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    seq_shift_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_val  (load_val),
        .load_n    (load_n),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .q         (q),
        .shift_out (shift_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_n   = 1'b0;
        load_val = v;
        tick();
        load_n   = 1'b1;
    endtask

    task automatic run_cmd(input logic [2:0] m, input logic [3:0] a,
                           output int busy_cnt, output int done_cnt, output bit finished);
        busy_cnt = 0;
        done_cnt = 0;
        finished = 1'b0;
        mode     = m;
        amount   = a;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                finished = 1'b1;
            end else if (finished) begin
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_n = 1'b0; load_val = 8'hAA; start = 1'b1; mode = 3'd0; amount = 4'd3;
        #3;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
        checks++; if ({shift_out, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {shift_out, busy, done}); end
        tick(); tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_hold_q: got %h want 00", q); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        reset_n = 1'b1; load_n = 1'b1; start = 1'b0;
        tick();
    endtask

    task automatic test_asr();
        do_load(8'b1001_0110);
        mode = 3'd1; amount = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (q !== 8'h96 || busy !== 1'b1) begin errors++; $display("FAIL asr_accept: got q=%h busy=%b want q=96 busy=1", q, busy); end
        tick();
        checks++; if (q !== 8'hCB || shift_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL asr_step1: got q=%h so=%b busy=%b want q=cb so=0 busy=1", q, shift_out, busy); end
        tick();
        checks++; if (q !== 8'hE5 || shift_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL asr_step2: got q=%h so=%b busy=%b want q=e5 so=1 busy=1", q, shift_out, busy); end
        tick();
        checks++; if (q !== 8'hF2 || shift_out !== 1'b1) begin errors++; $display("FAIL asr_final: got q=%h so=%b want q=f2 so=1", q, shift_out); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL asr_done: got done=%b busy=%b want 1 0", done, busy); end
        tick();
        checks++; if (done !== 1'b0 || q !== 8'hF2) begin errors++; $display("FAIL asr_after: got done=%b q=%h want 0 f2", done, q); end
    endtask

    task automatic test_lsr_lsl();
        int  bc, dc;
        bit  fin;
        do_load(8'b1001_0110);
        run_cmd(3'd0, 4'd3, bc, dc, fin);
        checks++; if (q !== 8'h12 || shift_out !== 1'b1) begin errors++; $display("FAIL lsr_q: got q=%h so=%b want 12 1", q, shift_out); end
        checks++; if (!fin || bc != 3 || dc != 1) begin errors++; $display("FAIL lsr_timing: got fin=%0d busy=%0d done=%0d want 1 3 1", fin, bc, dc); end
        do_load(8'h81);
        run_cmd(3'd2, 4'd1, bc, dc, fin);
        checks++; if (q !== 8'h02 || shift_out !== 1'b1) begin errors++; $display("FAIL lsl_q: got q=%h so=%b want 02 1", q, shift_out); end
        checks++; if (!fin || bc != 1 || dc != 1) begin errors++; $display("FAIL lsl_timing: got fin=%0d busy=%0d done=%0d want 1 1 1", fin, bc, dc); end
    endtask

    task automatic test_rotate();
        int  bc, dc;
        bit  fin;
        do_load(8'hA5);
        run_cmd(3'd4, 4'd4, bc, dc, fin);
        checks++; if (q !== 8'h5A || shift_out !== 1'b0) begin errors++; $display("FAIL rol4: got q=%h so=%b want 5a 0", q, shift_out); end
        run_cmd(3'd3, 4'd8, bc, dc, fin);
        checks++; if (q !== 8'h5A || shift_out !== 1'b0) begin errors++; $display("FAIL ror8: got q=%h so=%b want 5a 0", q, shift_out); end
        checks++; if (!fin || bc != 8 || dc != 1) begin errors++; $display("FAIL ror8_timing: got fin=%0d busy=%0d done=%0d want 1 8 1", fin, bc, dc); end
    endtask

    task automatic test_saturate();
        int  bc, dc;
        bit  fin;
        do_load(8'h96);
        run_cmd(3'd1, 4'd15, bc, dc, fin);
        checks++; if (q !== 8'hFF || shift_out !== 1'b1 || bc != 15) begin errors++; $display("FAIL asr15: got q=%h so=%b busy=%0d want ff 1 15", q, shift_out, bc); end
        do_load(8'hFF);
        run_cmd(3'd0, 4'd9, bc, dc, fin);
        checks++; if (q !== 8'h00 || shift_out !== 1'b0) begin errors++; $display("FAIL lsr9: got q=%h so=%b want 00 0", q, shift_out); end
        do_load(8'hA5);
        run_cmd(3'd4, 4'd9, bc, dc, fin);
        checks++; if (q !== 8'h4B || shift_out !== 1'b1) begin errors++; $display("FAIL rol9: got q=%h so=%b want 4b 1", q, shift_out); end
    endtask

    task automatic test_hold();
        int  bc, dc;
        bit  fin;
        run_cmd(3'd6, 4'd3, bc, dc, fin);
        checks++; if (q !== 8'h4B || shift_out !== 1'b1) begin errors++; $display("FAIL hold_q: got q=%h so=%b want 4b 1", q, shift_out); end
        checks++; if (!fin || bc != 3 || dc != 1) begin errors++; $display("FAIL hold_timing: got fin=%0d busy=%0d done=%0d want 1 3 1", fin, bc, dc); end
    endtask

    task automatic test_zero_amount();
        do_load(8'h3C);
        mode = 3'd0; amount = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h3C) begin errors++; $display("FAIL zero_done: got done=%b busy=%b q=%h want 1 0 3c", done, busy, q); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h3C) begin errors++; $display("FAIL zero_after: got done=%b busy=%b q=%h want 0 0 3c", done, busy, q); end
    endtask

    task automatic test_reset_mid_shift();
        do_load(8'hFF);
        mode = 3'd0; amount = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (q !== 8'h7F) begin errors++; $display("FAIL mid_step1: got %h want 7f", q); end
        load_n = 1'b0; load_val = 8'h00; start = 1'b1; mode = 3'd2; amount = 4'd1;
        tick();
        load_n = 1'b1; start = 1'b0;
        checks++; if (q !== 8'h3F || busy !== 1'b1 || shift_out !== 1'b1) begin errors++; $display("FAIL mid_ignore: got q=%h busy=%b so=%b want 3f 1 1", q, busy, shift_out); end
        reset_n = 1'b0;
        #2;
        checks++; if (q !== 8'h00 || {shift_out, busy, done} !== 3'b000) begin errors++; $display("FAIL mid_reset: got q=%h flags=%b want 00 000", q, {shift_out, busy, done}); end
        checks++; if (dut.state_q !== ST_IDLE || dut.cnt_q !== 4'd0 || dut.mode_q !== MODE_HOLD) begin errors++; $display("FAIL mid_reset_state: got st=%0d cnt=%0d mode=%0d want 0 0 5", dut.state_q, dut.cnt_q, dut.mode_q); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        do_load(8'h3C);
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL post_reset_load: got %h want 3c", q); end
    endtask

    task automatic test_done_collision();
        do_load(8'h10);
        mode = 3'd2; amount = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b1 || q !== 8'h20) begin errors++; $display("FAIL coll_done: got done=%b q=%h want 1 20", done, q); end
        load_n = 1'b0; load_val = 8'hC3; start = 1'b1; mode = 3'd2; amount = 4'd2;
        tick();
        load_n = 1'b1; start = 1'b0;
        checks++; if (q !== 8'hC3 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL coll_load: got q=%h busy=%b done=%b want c3 0 0", q, busy, done); end
        tick();
        checks++; if (q !== 8'hC3 || busy !== 1'b0) begin errors++; $display("FAIL coll_noshift: got q=%h busy=%b want c3 0", q, busy); end
    endtask

    task automatic test_back_to_back();
        do_load(8'h01);
        mode = 3'd2; amount = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b1 || q !== 8'h02) begin errors++; $display("FAIL b2b_first: got done=%b q=%h want 1 02", done, q); end
        amount = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h02) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b q=%h want 1 0 02", busy, done, q); end
        tick();
        checks++; if (q !== 8'h04 || busy !== 1'b1) begin errors++; $display("FAIL b2b_step1: got q=%h busy=%b want 04 1", q, busy); end
        tick();
        checks++; if (q !== 8'h08 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_final: got q=%h done=%b busy=%b want 08 1 0", q, done, busy); end
        tick();
    endtask

    initial begin
        reset_n  = 1'b0;
        load_n   = 1'b1;
        load_val = 8'h00;
        start    = 1'b0;
        mode     = 3'd0;
        amount   = 4'd0;
        test_reset();
        test_asr();
        test_lsr_lsl();
        test_rotate();
        test_saturate();
        test_hold();
        test_zero_amount();
        test_reset_mid_shift();
        test_done_collision();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
